// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port: one dead cycle to arbitrate, then up to MAX_BURST beats back-to-back.
// fifoFull stalls the burst combinationally with the grant held, so no write is ever issued while full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifoFull,
  output logic                          fifoWrEn,
  output logic [DATA_WIDTH-1:0]         fifoWrData,
  output logic [$clog2(NUM_REQ)-1:0]    grantId,
  output logic                          busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [ID_W-1:0]  LAST_RST  = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   last_grant, last_nxt, grant_nxt;
  logic [ID_W-1:0]   winner, cand;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic              found, cur_req, accept;

  // First requester at or after last_grant+1, wrapping modulo NUM_REQ.
  always_comb begin
    winner = last_grant;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    cur_req    = 1'b0;
    fifoWrData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantId == ID_W'(i)) begin
        cur_req = req[i];
        if (state == GRANT) fifoWrData = reqData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign accept   = (state == GRANT) && cur_req && !fifoFull && !reset;
  assign fifoWrEn = accept;
  assign busy     = (state == GRANT);

  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = accept && (grantId == ID_W'(i));
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grantId;
    last_nxt     = last_grant;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt    = GRANT;
          grant_nxt    = winner;
          last_nxt     = winner;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        // A dropped request ends the burst early; a full FIFO simply holds everything.
        if (!cur_req) begin
          state_nxt = IDLE;
        end else if (accept) begin
          if (beat_cnt == BEAT_LAST) state_nxt = IDLE;
          else                       beat_cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grantId    <= '0;
      last_grant <= LAST_RST;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grantId    <= grant_nxt;
      last_grant <= last_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-backed producers and a burst-level reference model, directed phases then random traffic.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] reqData;
  logic [N-1:0]   ack;
  logic           fifoFull;
  logic           fifoWrEn;
  logic [W-1:0]   fifoWrData;
  logic [1:0]     grantId;
  logic           busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .reqData(reqData), .ack(ack),
    .fifoFull(fifoFull), .fifoWrEn(fifoWrEn), .fifoWrData(fifoWrData),
    .grantId(grantId), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Producers: each requester drains its own queue of beats.
  logic [7:0] pq[N][$];
  logic [7:0] sent_log[N][$];
  logic [7:0] wr_log[N][$];
  int cont_pct  = 100;
  int raise_pct = 100;

  // Reference model: burst-level view of the arbiter.
  bit m_busy;
  int m_owner, m_last, m_beats;

  // Per-phase observations.
  bit   armed = 1'b0;
  int   cyc;
  int   wcyc[$];
  logic [7:0] wdat[$];
  int   gseq[$];
  bit   prev_busy;
  bit   bh[64];
  bit   wh[64];
  int   gh[64];
  int   phase_writes;

  int exp_a[6] = '{1, 2, 3, 4, 6, 7};
  int exp_c[4] = '{1, 2, 8, 9};

  task automatic drive_data();
    for (int i = 0; i < N; i++)
      reqData[i*W +: W] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
  endtask

  task automatic load(input int id, input int n, input logic [7:0] base);
    for (int s = 0; s < n; s++) pq[id].push_back(base + 8'(s));
    req[id] = 1'b1;
    drive_data();
  endtask

  // One clock: inputs were driven at posedge+1; check at posedge+3, then advance model and producers.
  task automatic cycle();
    bit           acc;
    bit           found;
    int           win;
    logic [N-1:0] e_ack;
    logic [W-1:0] e_dat;
    bit           popped[N];
    #2;
    acc   = m_busy && req[m_owner] && !fifoFull && !reset;
    e_ack = '0;
    if (acc) e_ack[m_owner] = 1'b1;
    e_dat = m_busy ? reqData[m_owner*W +: W] : 8'h00;
    if (armed) begin
      check("ack", ack, e_ack);
      check("wr_en", fifoWrEn, acc);
      check("wr_data", fifoWrData, e_dat);
      check("grant_id", grantId, m_owner);
      check("busy", busy, m_busy);
      check("no_wr_full", fifoWrEn & fifoFull, 0);
      check("ack_onehot0", $onehot0(ack), 1);
    end
    armed = 1'b1;
    if (fifoWrEn === 1'b1 && !$isunknown(grantId)) begin
      wr_log[grantId].push_back(fifoWrData);
      wcyc.push_back(cyc);
      wdat.push_back(fifoWrData);
      phase_writes++;
    end
    if (busy === 1'b1 && !prev_busy) gseq.push_back(int'(grantId));
    prev_busy = (busy === 1'b1);
    if (cyc < 64) begin
      bh[cyc] = (busy === 1'b1);
      wh[cyc] = (fifoWrEn === 1'b1);
      gh[cyc] = int'(grantId);
    end
    popped = '{default: 1'b0};
    if (acc) begin
      popped[m_owner] = 1'b1;
      sent_log[m_owner].push_back(pq[m_owner].pop_front());
    end
    if (reset) begin
      m_busy = 1'b0; m_owner = 0; m_last = N - 1; m_beats = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      win   = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && req[(m_last + k) % N]) begin
          found = 1'b1;
          win   = (m_last + k) % N;
        end
      end
      if (found) begin
        m_busy = 1'b1; m_owner = win; m_last = win; m_beats = 0;
      end
    end else if (!req[m_owner]) begin
      m_busy = 1'b0;
    end else if (acc) begin
      m_beats++;
      if (m_beats == MB) m_busy = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (popped[i])
        req[i] = (pq[i].size() > 0) && ($urandom_range(99) < cont_pct);
      else if (!req[i] && pq[i].size() > 0 && $urandom_range(99) < raise_pct)
        req[i] = 1'b1;
    end
    drive_data();
  endtask

  task automatic start_phase();
    reset    = 1'b1;
    fifoFull = 1'b0;
    req      = '0;
    for (int i = 0; i < N; i++) pq[i].delete();
    drive_data();
    cycle();
    cycle();
    reset = 1'b0;
    wcyc.delete(); wdat.delete(); gseq.delete();
    prev_busy    = 1'b0;
    phase_writes = 0;
    cyc          = 0;
    for (int c = 0; c < 64; c++) begin bh[c] = 1'b0; wh[c] = 1'b0; gh[c] = -1; end
  endtask

  initial begin
    int idl;
    int guard;
    int mm;
    bit pending;
    reset = 1'b1; req = '0; reqData = '0; fifoFull = 1'b0;
    m_busy = 1'b0; m_owner = 0; m_last = N - 1; m_beats = 0; cyc = 0;
    @(posedge clk);
    #1;

    // Single requester, 6 beats: burst of 4, dead cycle, burst of 2.
    start_phase();
    load(0, 6, 8'hA0);
    repeat (10) cycle();
    check("A_nwr", wcyc.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < wcyc.size()) begin
        check("A_wcyc", wcyc[k], exp_a[k]);
        check("A_wdat", wdat[k], 8'hA0 + k);
      end
    end
    check("A_busy4", bh[4], 1);
    check("A_idle5", bh[5], 0);

    // All requesting: rotation 0,1,2,3 with one idle cycle between bursts.
    start_phase();
    for (int i = 0; i < N; i++) load(i, 30, 8'(i * 64));
    repeat (60) cycle();
    check("B_nwr", phase_writes, 48);
    check("B_ngrants", gseq.size(), 12);
    for (int k = 0; k < 12; k++)
      if (k < gseq.size()) check("B_order", gseq[k], k % N);
    idl = 0;
    for (int c = 0; c < 60; c++) if (!bh[c]) idl++;
    check("B_idle", idl, 12);

    // Requester 2 stalled by fifoFull after 2 beats for 5 cycles.
    start_phase();
    load(2, 4, 8'h80);
    for (int c = 0; c < 12; c++) begin
      fifoFull = (c >= 3 && c <= 7);
      cycle();
    end
    fifoFull = 1'b0;
    check("C_nwr", wcyc.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < wcyc.size()) begin
        check("C_wcyc", wcyc[k], exp_c[k]);
        check("C_wdat", wdat[k], 8'h80 + k);
      end
    end
    check("C_hold_gid", gh[5], 2);
    check("C_hold_busy", bh[7], 1);
    check("C_stall_wr", wh[5], 0);

    // Requester 1 drops after one beat; requester 3 wins next.
    start_phase();
    load(1, 1, 8'h40);
    load(3, 4, 8'hC0);
    repeat (10) cycle();
    check("D_ngrants", gseq.size(), 2);
    if (gseq.size() >= 2) begin
      check("D_g0", gseq[0], 1);
      check("D_g1", gseq[1], 3);
    end
    check("D_busy2", bh[2], 1);
    check("D_idle3", bh[3], 0);
    if (wcyc.size() >= 2) begin
      check("D_w0", wcyc[0], 1);
      check("D_w1", wcyc[1], 4);
      check("D_d1", wdat[1], 8'hC0);
    end

    // Reset on the second beat of requester 1's burst.
    start_phase();
    for (int i = 0; i < N; i++) load(i, 20, 8'(i * 64));
    for (int c = 0; c < 12; c++) begin
      reset = (c == 7);
      cycle();
    end
    reset = 1'b0;
    check("E_beat1_wr", wh[6], 1);
    check("E_beat1_gid", gh[6], 1);
    check("E_rst_wr", wh[7], 0);
    check("E_post_busy", bh[8], 0);
    check("E_post_gid", gh[8], 0);
    check("E_post_wr", wh[8], 0);
    check("E_regrant_gid", gh[9], 0);
    check("E_regrant_busy", bh[9], 1);

    // Random traffic with random backpressure and early drops.
    start_phase();
    cont_pct  = 75;
    raise_pct = 40;
    for (int i = 0; i < N; i++) load(i, 260, 8'(i * 64));
    guard   = 0;
    pending = 1'b1;
    while (pending && guard < 20000) begin
      fifoFull = ($urandom_range(99) < 25);
      cycle();
      guard++;
      pending = 1'b0;
      for (int i = 0; i < N; i++) if (pq[i].size() > 0) pending = 1'b1;
    end
    fifoFull = 1'b0;
    repeat (3) cycle();
    check("F_done", guard < 20000, 1);
    check("F_nwr", phase_writes, 1040);

    for (int i = 0; i < N; i++) begin
      check("sb_count", wr_log[i].size(), sent_log[i].size());
      mm = 0;
      for (int k = 0; k < wr_log[i].size() && k < sent_log[i].size(); k++)
        if (wr_log[i][k] !== sent_log[i][k]) mm++;
      check("sb_order", mm, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
